wb_spi_master: RTL and testbench
================================

# wb_spi_master

Wishbone-slave SPI master occupying slave port 2 of the user-area `wb_interconnect`, beside the SRAM wrapper (slave 0) and UART (slave 1). Software writes a byte and the block shifts it out MSB-first on SPI pads while capturing MISO. It supports CPOL/CPHA modes 0–3, a programmable SCLK divider, software-controlled chip select, and a done interrupt.

## Interface
Parameters:
- `ADDR_WD`, 9, Wishbone address width as delivered by the interconnect.
- `DIV_RST`, 16'h0003, reset value of the DIV register.

Ports (one clock; reset is synchronous and active-high):
- `wb_clk_i`  in  1  system clock
- `wb_rst_i`  in  1  synchronous active-high reset
- `wb_cyc_i`  in  1  cycle
- `wb_stb_i`  in  1  strobe
- `wb_we_i`  in  1  write enable
- `wb_sel_i`  in  4  byte lanes
- `wb_adr_i`  in  ADDR_WD  byte address
- `wb_dat_i`  in  32  write data
- `wb_dat_o`  out  32  read data, valid while `wb_ack_o`=1, otherwise 0
- `wb_ack_o`  out  1  acknowledge
- `spi_sclk`  out  1  serial clock
- `spi_mosi`  out  1  master out
- `spi_miso`  in  1  master in
- `spi_csn`  out  1  chip select, active low
- `irq_o`  out  1  interrupt, level

## Operation
Register decode:
- Decode uses `wb_adr_i[3:2]`.
- If `wb_adr_i[ADDR_WD-1:4]` is nonzero, the access is unmapped: reads return 0, writes are ignored, and the access is still acked.

Registers:
- 0x00 CTRL, reset 0.
  - [0] EN.
  - [1] CPOL.
  - [2] CPHA.
  - [3] CS: `spi_csn` = ~CS, applied immediately.
  - [4] IE.
  - Written through `wb_sel_i[0]`.
- 0x04 DIV [15:0], reset DIV_RST. Written through `wb_sel_i[1:0]` per byte.
- 0x08 DATA.
  - A write with `sel[0]`, EN=1 and BUSY=0 loads `dat_i[7:0]` into the shift register and starts a transfer.
  - A write while BUSY=1 is dropped and sets OVR.
  - A write with EN=0 is dropped silently.
  - A read returns the last received byte in [7:0], reset 0.
- 0x0C STATUS.
  - [0] BUSY, read-only.
  - [1] DONE, sticky.
  - [2] OVR, sticky.
  - Writing 1 with `sel[0]` clears DONE/OVR.
- Reserved bits read 0.

Interrupt: `irq_o` = DONE & IE.

Transfer latch: CPOL, CPHA and DIV are latched at transfer start. Later writes to them affect only the next transfer. CPOL also sets the SCLK idle level immediately while idle.

FSM:
- IDLE.
  - `spi_sclk`=CPOL.
  - DATA write accepted → XFER. Load the half-period counter with DIV and the edge counter with 0.
- XFER.
  - The half-period counter decrements each cycle. At 0 it reloads, toggles SCLK and increments the edge count (1..16).
  - Odd edges are leading edges; even edges are trailing edges.
  - CPHA=0: MOSI = bit7 from transfer start. Sample MISO on leading edges, shift MOSI on trailing edges, except no shift after edge 16.
  - CPHA=1: MOSI updates to the next bit on leading edges, starting with bit7 at edge 1. Sample on trailing edges.
  - After edge 16 → DONE_ST.
- DONE_ST, one cycle.
  - RX register ← captured byte, DONE ← 1, BUSY ← 0.
  - → IDLE.
- EN cleared during XFER aborts the transfer.
  - → IDLE immediately, SCLK returns to CPOL.
  - DONE is not set and the RX register is unchanged.
- `spi_mosi` is 0 in IDLE.

## Timing
- Ack: registered. `wb_ack_o` rises the cycle after `cyc&stb` is sampled with ack low, and stays high exactly 1 cycle. Every access therefore takes 2 cycles, and back-to-back strobes are acked on alternate cycles.
- Write commit: a write takes effect in the cycle `wb_ack_o`=1. BUSY reads 1 from the following cycle.
- Half period: (DIV+1) cycles.
- SCLK edge timing: edge k occurs k·(DIV+1) cycles after XFER entry.
- Transfer length: BUSY is high for 16·(DIV+1)+1 cycles. DONE and the RX register update on the cycle BUSY falls.
- DONE priority: if DONE is being set and a W1C hits it in the same cycle, set wins. The same rule applies to OVR.
- Reset values (any cycle, including mid-transfer):
  - `spi_sclk`=0, `spi_csn`=1, `spi_mosi`=0, `irq_o`=0, `wb_ack_o`=0, `wb_dat_o`=0.
  - FSM → IDLE.
  - All registers return to their reset values.

## Test plan
- Reset: assert `wb_rst_i` for 2 cycles → all outputs at reset values. CTRL reads 0, DIV reads 0x0003, STATUS reads 0, and each read is acked exactly 1 cycle after stb.
- Mode 0 loopback (MISO tied to MOSI):
  - Setup: CTRL=0x19 (EN, CS, IE), DIV=0, write DATA=0xA5.
  - Required: 8 SCLK pulses at period 2, BUSY high 17 cycles, MOSI pattern 1010_0101, `spi_csn`=0.
  - Completion: DATA reads 0xA5, DONE=1, `irq_o`=1. Writing STATUS=0x2 drops irq.
- Mode 3 with slave model returning 0x3C:
  - Setup: CTRL=0x0F, DIV=2.
  - Required: SCLK idles high, MOSI changes on falling edges, BUSY high 49 cycles, DATA reads 0x3C, `irq_o` stays 0 (IE=0).
- Overrun: write DATA=0x11 during a transfer of 0x55 → OVR=1 and the wire still carries 0x55. W1C of 0x4 clears OVR; the same-cycle set+clear case leaves OVR=1.
- Abort:
  - Write CTRL=0x08 (EN cleared) at edge 5 → SCLK returns to idle next cycle, BUSY=0, DONE=0, DATA read unchanged.
  - Repeat the abort using `wb_rst_i` → reset values.
- Decode and lanes:
  - Write DIV=0x1234 with sel=4'b0010 → DIV reads 0x1203 (only [15:8] written over the reset value 0x0003).
  - Read 0x10 or 0x1F0 → 0 with ack.

Source files
------------

// File: rtl/wb_spi_master.sv
// Wishbone slave SPI master: one byte per transfer, CPOL/CPHA modes 0-3,
// programmable SCLK half-period, software chip select and done interrupt.
module wb_spi_master #(
    parameter int          ADDR_WD = 9,
    parameter logic [15:0] DIV_RST = 16'h0003
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [3:0]         wb_sel_i,
    input  logic [ADDR_WD-1:0] wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               spi_sclk,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic               spi_csn,
    output logic               irq_o
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t      r_state;
    logic        r_ack;
    logic [31:0] r_dat_o;
    logic        r_req_we, r_req_map;
    logic [1:0]  r_req_adr, r_req_sel;
    logic [15:0] r_req_dat;
    logic        r_en, r_cpol, r_cpha, r_cs, r_ie;
    logic [15:0] r_div, r_div_l, r_cnt;
    logic [7:0]  r_rxd, r_tx, r_rx;
    logic        r_done, r_ovr, r_cpha_l, r_sclk, r_mosi;
    logic [4:0]  r_edge;

    logic        w_req, w_mapped, w_busy, w_wr;
    logic        w_wr_ctrl, w_wr_div, w_wr_data, w_wr_stat;
    logic        w_start, w_abort, w_set_ovr, w_lead;
    logic [4:0]  w_edge_n;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_mapped  = (wb_adr_i[ADDR_WD-1:4] == '0);
    assign w_busy    = (r_state != S_IDLE);
    // Writes are captured at the request edge and committed as the ack cycle ends.
    assign w_wr      = r_ack & r_req_we & r_req_map;
    assign w_wr_ctrl = w_wr & (r_req_adr == 2'd0) & r_req_sel[0];
    assign w_wr_div  = w_wr & (r_req_adr == 2'd1);
    assign w_wr_data = w_wr & (r_req_adr == 2'd2) & r_req_sel[0];
    assign w_wr_stat = w_wr & (r_req_adr == 2'd3) & r_req_sel[0];
    assign w_start   = w_wr_data & r_en & ~w_busy;
    assign w_set_ovr = w_wr_data & w_busy;
    assign w_abort   = (r_state == S_XFER) & (~r_en | (w_wr_ctrl & ~r_req_dat[0]));
    assign w_edge_n  = r_edge + 5'd1;
    assign w_lead    = w_edge_n[0];
    assign w_unused  = ^{wb_sel_i[3:2], wb_dat_i[31:16], wb_adr_i[1:0]};

    always_comb begin
        w_rdata = '0;
        if (w_mapped) begin
            case (wb_adr_i[3:2])
                2'd0:    w_rdata = {27'd0, r_ie, r_cs, r_cpha, r_cpol, r_en};
                2'd1:    w_rdata = {16'd0, r_div};
                2'd2:    w_rdata = {24'd0, r_rxd};
                default: w_rdata = {29'd0, r_ovr, r_done, w_busy};
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat_o   <= '0;
            r_req_we  <= 1'b0;
            r_req_map <= 1'b0;
            r_req_adr <= '0;
            r_req_sel <= '0;
            r_req_dat <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat_o <= (w_req & ~wb_we_i) ? w_rdata : '0;
            if (w_req) begin
                r_req_we  <= wb_we_i;
                r_req_map <= w_mapped;
                r_req_adr <= wb_adr_i[3:2];
                r_req_sel <= wb_sel_i[1:0];
                r_req_dat <= wb_dat_i[15:0];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            {r_ie, r_cs, r_cpha, r_cpol, r_en} <= '0;
            r_div  <= DIV_RST;
            r_rxd  <= '0;
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_wr_ctrl) {r_ie, r_cs, r_cpha, r_cpol, r_en} <= r_req_dat[4:0];
            if (w_wr_div && r_req_sel[0]) r_div[7:0]  <= r_req_dat[7:0];
            if (w_wr_div && r_req_sel[1]) r_div[15:8] <= r_req_dat[15:8];
            if (r_state == S_DONE) r_rxd <= r_rx;
            // Setting a sticky flag outranks a simultaneous write-one-to-clear.
            if (r_state == S_DONE)              r_done <= 1'b1;
            else if (w_wr_stat && r_req_dat[1]) r_done <= 1'b0;
            if (w_set_ovr)                      r_ovr <= 1'b1;
            else if (w_wr_stat && r_req_dat[2]) r_ovr <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div_l  <= '0;
            r_cpha_l <= 1'b0;
            r_edge   <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_tx     <= '0;
            r_rx     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mosi <= 1'b0;
                    if (w_start) begin
                        r_state  <= S_XFER;
                        r_cnt    <= r_div;
                        r_div_l  <= r_div;
                        r_cpha_l <= r_cpha;
                        r_edge   <= '0;
                        r_sclk   <= r_cpol;
                        r_tx     <= r_req_dat[7:0];
                        r_rx     <= '0;
                        r_mosi   <= r_cpha ? 1'b0 : r_req_dat[7];
                    end
                end
                S_XFER: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_mosi  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_cnt  <= r_div_l;
                        r_sclk <= ~r_sclk;
                        r_edge <= w_edge_n;
                        if (w_lead == ~r_cpha_l) begin
                            r_rx <= {r_rx[6:0], spi_miso};
                        end else if (r_cpha_l) begin
                            r_mosi <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end else if (w_edge_n != 5'd16) begin
                            r_mosi <= r_tx[6];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                        if (w_edge_n == 5'd16) r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat_o;
    assign spi_sclk = (r_state == S_IDLE) ? r_cpol : r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_csn  = ~r_cs;
    assign irq_o    = r_done & r_ie;

endmodule

// File: tb/tb_wb_spi_master.sv
// Directed bench for wb_spi_master: register access, modes 0/3, overrun,
// sticky-flag priority, abort by EN and by reset, address decode and lanes.
module tb_wb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [8:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        ack, sclk, mosi, miso, csn, irq;

    logic        loop = 1'b0, slave_en = 1'b0, slave_miso = 1'b0;
    logic [7:0]  sh = '0, mon = '0;
    logic        prev_sclk = 1'b0, prev_mosi = 1'b0, prev_irq = 1'b0;
    logic        m_rise, m_fall;
    int          n_chk = 0, n_fail = 0, cyc_cnt = 0, t0 = 0;
    int          n_edges = 0, n_rise = 0, first_edge = -1, last_edge = -1;
    int          mosi_bad = 0, irq_rise = -1;
    logic [31:0] v;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    assign miso = loop ? mosi : slave_miso;

    wb_spi_master #(.ADDR_WD(9), .DIV_RST(16'h0003)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .spi_sclk(sclk), .spi_mosi(mosi),
        .spi_miso(miso), .spi_csn(csn), .irq_o(irq)
    );

    // Pin monitor and mode-3 slave, sampled mid-cycle.
    always @(negedge clk) begin
        m_rise = (sclk === 1'b1) && (prev_sclk === 1'b0);
        m_fall = (sclk === 1'b0) && (prev_sclk === 1'b1);
        if (sclk !== prev_sclk) begin
            n_edges++;
            last_edge = cyc_cnt;
            if (first_edge < 0) first_edge = cyc_cnt;
        end
        if (m_rise) begin
            n_rise++;
            mon = {mon[6:0], mosi};
        end
        if (m_fall && slave_en) begin
            slave_miso = sh[7];
            sh = {sh[6:0], 1'b0};
        end
        if ((mosi !== prev_mosi) && !m_fall) mosi_bad++;
        if ((irq === 1'b1) && (prev_irq !== 1'b1)) irq_rise = cyc_cnt;
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_irq  = irq;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        n_edges = 0; n_rise = 0; first_edge = -1; last_edge = -1;
        mon = '0; mosi_bad = 0; irq_rise = -1;
    endtask

    // Called at a negedge; returns at the negedge after the ack cycle.
    task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = s;
        @(negedge clk);
        check("wr_ack_rise", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("wr_ack_fall", {31'd0, ack}, 32'd0);
    endtask

    task automatic rd(input logic [8:0] a, output logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        @(negedge clk);
        check("rd_ack_rise", {31'd0, ack}, 32'd1);
        d = dat_o;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("rd_ack_fall", {31'd0, ack}, 32'd0);
        check("rd_dat_idle", dat_o, 32'd0);
    endtask

    task automatic rdc(input string tag, input logic [8:0] a, input logic [31:0] exp);
        logic [31:0] r;
        rd(a, r);
        check(tag, r, exp);
    endtask

    task automatic chk_reset_pins();
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_csn",  {31'd0, csn},  32'd1);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_irq",  {31'd0, irq},  32'd0);
        check("rst_ack",  {31'd0, ack},  32'd0);
        check("rst_dato", dat_o, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_pins();
        rdc("rst_ctrl", 9'h00, 32'h0);
        rdc("rst_div",  9'h04, 32'h3);
        rdc("rst_stat", 9'h0C, 32'h0);
        rdc("rst_data", 9'h08, 32'h0);

        // Mode 0 loopback, DIV=0
        loop = 1'b1;
        wr(9'h00, 32'h19, 4'h1);
        wr(9'h04, 32'h0, 4'h3);
        check("m0_csn", {31'd0, csn}, 32'd0);
        clr_mon();
        wr(9'h08, 32'hA5, 4'h1);
        t0 = cyc_cnt;
        rdc("m0_busy0", 9'h0C, 32'h1);
        repeat (14) @(negedge clk);
        rdc("m0_busy16", 9'h0C, 32'h1);
        check("m0_rises", n_rise, 8);
        check("m0_edges", n_edges, 16);
        check("m0_edge1_t", first_edge - t0, 1);
        check("m0_edge16_t", last_edge - t0, 16);
        check("m0_mosi", {24'd0, mon}, 32'hA5);
        check("m0_irq_t", irq_rise - t0, 17);
        rdc("m0_stat", 9'h0C, 32'h2);
        rdc("m0_data", 9'h08, 32'hA5);
        check("m0_irq", {31'd0, irq}, 32'd1);
        wr(9'h0C, 32'h2, 4'h1);
        check("m0_irq_clr", {31'd0, irq}, 32'd0);

        // Mode 3, slave returns 0x3C, DIV=2
        loop = 1'b0; slave_en = 1'b1; sh = 8'h3C;
        wr(9'h00, 32'h0F, 4'h1);
        check("m3_idle_hi", {31'd0, sclk}, 32'd1);
        wr(9'h04, 32'h2, 4'h3);
        clr_mon();
        wr(9'h08, 32'h96, 4'h1);
        t0 = cyc_cnt;
        rdc("m3_busy0", 9'h0C, 32'h1);
        repeat (46) @(negedge clk);
        rdc("m3_busy48", 9'h0C, 32'h1);
        rdc("m3_stat50", 9'h0C, 32'h2);
        check("m3_edge1_t", first_edge - t0, 3);
        check("m3_edge16_t", last_edge - t0, 48);
        check("m3_rises", n_rise, 8);
        check("m3_mosi", {24'd0, mon}, 32'h96);
        check("m3_mosi_on_fall", mosi_bad, 0);
        check("m3_irq", {31'd0, irq}, 32'd0);
        check("m3_sclk_end", {31'd0, sclk}, 32'd1);
        rdc("m3_data", 9'h08, 32'h3C);
        slave_en = 1'b0;
        wr(9'h0C, 32'h2, 4'h1);

        // Overrun during a transfer of 0x55, DIV=1
        loop = 1'b1;
        wr(9'h00, 32'h19, 4'h1);
        wr(9'h04, 32'h1, 4'h3);
        clr_mon();
        wr(9'h08, 32'h55, 4'h1);
        wr(9'h08, 32'h11, 4'h1);
        rdc("ovr_set", 9'h0C, 32'h5);
        repeat (30) @(negedge clk);
        rdc("ovr_done", 9'h0C, 32'h6);
        check("ovr_wire", {24'd0, mon}, 32'h55);
        rdc("ovr_data", 9'h08, 32'h55);
        wr(9'h0C, 32'h4, 4'h1);
        rdc("ovr_w1c", 9'h0C, 32'h2);
        wr(9'h0C, 32'h2, 4'h1);

        // DONE set and W1C committing on the same edge, DIV=0
        wr(9'h04, 32'h0, 4'h3);
        clr_mon();
        wr(9'h08, 32'hC3, 4'h1);
        repeat (15) @(negedge clk);
        wr(9'h0C, 32'h2, 4'h1);
        rdc("done_set_wins", 9'h0C, 32'h2);
        check("done_irq", {31'd0, irq}, 32'd1);
        rdc("done_data", 9'h08, 32'hC3);
        wr(9'h0C, 32'h2, 4'h1);

        // Abort by clearing EN at edge 5, DIV=1
        wr(9'h04, 32'h1, 4'h3);
        clr_mon();
        wr(9'h08, 32'hF0, 4'h1);
        repeat (8) @(negedge clk);
        wr(9'h00, 32'h08, 4'h1);
        check("abt_sclk", {31'd0, sclk}, 32'd0);
        check("abt_mosi", {31'd0, mosi}, 32'd0);
        check("abt_csn", {31'd0, csn}, 32'd0);
        check("abt_edges", n_edges, 4);
        rdc("abt_stat", 9'h0C, 32'h0);
        rdc("abt_data", 9'h08, 32'hC3);
        check("abt_irq", {31'd0, irq}, 32'd0);

        // Abort by reset mid-transfer
        wr(9'h00, 32'h1F, 4'h1);
        wr(9'h04, 32'h5, 4'h3);
        wr(9'h08, 32'h77, 4'h1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_pins();
        rdc("rst2_ctrl", 9'h00, 32'h0);
        rdc("rst2_div",  9'h04, 32'h3);
        rdc("rst2_stat", 9'h0C, 32'h0);
        rdc("rst2_data", 9'h08, 32'h0);

        // Decode and byte lanes
        wr(9'h04, 32'h1234, 4'b0010);
        rdc("lane_div", 9'h04, 32'h1203);
        rdc("unmap_10", 9'h010, 32'h0);
        rdc("unmap_1f0", 9'h1F0, 32'h0);
        wr(9'h010, 32'h1F, 4'hF);
        rdc("unmap_wr", 9'h00, 32'h0);
        check("unmap_csn", {31'd0, csn}, 32'd1);
        wr(9'h00, 32'hFFFF_FFFF, 4'hF);
        rdc("rsvd_ctrl", 9'h00, 32'h1F);
        wr(9'h00, 32'h0, 4'h1);
        rd(9'h0C, v);
        check("rsvd_stat", v, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
